tm1638_responder: RTL
=====================

// Module: tm1638_responder
// PURPOSE
//  Device-side (slave) end of the TM1638 3-wire link: emulates the chip in FPGA fabric.
//  Decodes STB/CLK/DIO from a TM1638 master, holds 16x8 display RAM and display control,
//  and returns 4 bytes of key-scan data on read commands.
//  Used for loopback verification of the master and to drive non-TM1638 display hardware.
// PARAMETERS
//  SYNC_STAGES  2  flops in each input-pin synchronizer (stb_n, sclk_in, dio_in); min 2
// PORTS
//  clk         in   1   system clock; all logic on posedge
//  rst         in   1   reset, synchronous, active-high
//  stb_n       in   1   strobe from master, active-low frames a transaction
//  sclk_in     in   1   serial clock from master, idles high
//  dio_in      in   1   serial data from master
//  dio_out     out  1   serial data to master (key bytes)
//  dio_oe      out  1   1 = responder drives dio_out onto DIO pad
//  keys        in   32  key-scan image; read byte k = keys[8k+7:8k], k=0..3
//  ram_raddr   in   4   display RAM read address (async read)
//  ram_rdata   out  8   display RAM contents at ram_raddr
//  ram_we      out  1   1-cycle pulse per display byte written
//  ram_waddr   out  4   address of that write
//  ram_wdata   out  8   data of that write
//  display_on  out  1   display control bit 3
//  brightness  out  3   display control bits 2:0
// BEHAVIOUR
//  Reset: dio_out=0, dio_oe=0, ram_we=0, ram_waddr=0, ram_wdata=0, display_on=0,
//   brightness=0, all 16 RAM bytes=0x00, mode=write/auto-increment, addr ptr=0, state=S_IDLE.
//  Pins pass SYNC_STAGES flops; edges detected on synchronized copies. Master half-period on
//   sclk_in must be >= SYNC_STAGES+2 clk; shorter is unsupported.
//  Bits LSB first. Sample dio on sclk rising edge; responder drives on sclk falling edge.
//  3-bit bit counter; byte complete on 8th rising edge; byte acted on the next clk.
//  Command byte = first byte after stb_n falls, decoded on bits [7:6]:
//   01 data cmd:  bit1 1=read 0=write; bit2 1=fixed addr 0=auto-inc; bit3 ignored.
//   11 addr cmd:  addr ptr <= bits[3:0].
//   10 display:   display_on <= bit3, brightness <= bits[2:0].
//   00            ignored.
//  Mode (read/write, fixed/inc) persists across strobe windows until next data cmd.
//  States:
//   S_IDLE : stb_n high; dio_oe=0; bit ctr=0. stb_n fall -> S_CMD.
//   S_CMD  : shift 8 bits; then data cmd read -> S_RDATA (snapshot keys, byte idx=0);
//            addr cmd with mode=write -> S_WDATA; addr cmd with mode=read, any other -> S_IGNORE.
//   S_WDATA: each full byte -> RAM[ptr], ram_we pulse with ram_waddr=ptr, ram_wdata=byte;
//            ptr += 1 if auto-inc (15 wraps to 0), unchanged if fixed.
//   S_RDATA: dio_oe=1; on each sclk fall drive next bit of snapshot byte[idx];
//            after 8 bits idx += 1; idx > 3 drives 0s. dio_out changes only on falls.
//   S_IGNORE: consume bits, no effect.
//  stb_n rise in any state -> S_IDLE next clk: partial byte discarded, dio_oe=0,
//   dio_out=0; completed RAM writes kept.
//  Simultaneous stb_n rise and 8th sclk rise: stb_n wins, byte discarded.
//  RAM read port is combinational; a write is visible on ram_rdata the clk after ram_we.
//  Reset mid-transaction: immediate return to reset values; next frame needs a fresh stb_n fall.
// STRUCTURE
//  tm1638_defs.vh (shared with tm1638 master): command field codes 2'b01/2'b11/2'b10,
//   bit positions for read, fixed-addr, display-on, brightness.
//  Sub-module tm1638_pin_sync: SYNC_STAGES synchronizer + rise/fall pulses, 3 instances.
//  Top: FSM, shift reg, bit ctr, addr ptr, key snapshot, 16x8 register RAM.
// TESTING
//  Frame {0x40}, frame {0xC0,0x3F,0x06,0x5B} -> ram_we x3, RAM[0..2]=3F,06,5B.
//  Frame {0x44}, frame {0xC5,0x11,0x22} -> RAM[5]=0x22, RAM[6] unchanged 0x00.
//  Auto-inc, {0xCF,0xAA,0xBB} -> RAM[15]=AA, RAM[0]=BB (wrap).
//  keys=32'h8040_2010, frame {0x42} + 5 read bytes -> master gets 10,20,40,80,00.
//  Frame {0x8B} -> display_on=1, brightness=3; {0x80} -> display_on=0, brightness=0.
//  stb_n high after 5 bits of data byte, and rst mid-read -> no ram_we, dio_oe=0 next clk.

Source files
------------

// File: rtl/tm1638_responder_pkg.sv
// Shared TM1638 command encodings and responder FSM state type.
package tm1638_responder_pkg;

  localparam logic [1:0] CMD_DATA = 2'b01;
  localparam logic [1:0] CMD_ADDR = 2'b11;
  localparam logic [1:0] CMD_DISP = 2'b10;

  localparam int BIT_READ    = 1;
  localparam int BIT_FIXED   = 2;
  localparam int BIT_DISP_ON = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WDATA,
    S_RDATA,
    S_IGNORE
  } state_t;

  function automatic logic [1:0] cmd_field(input logic [7:0] b);
    return b[7:6];
  endfunction

endpackage

// File: rtl/tm1638_responder_if.sv
// TM1638 3-wire pin bundle as seen from the master and from the responder.
interface tm1638_responder_if;
  logic stb_n;
  logic sclk_in;
  logic dio_in;
  logic dio_out;
  logic dio_oe;

  modport master (output stb_n, sclk_in, dio_in, input dio_out, dio_oe);
  modport slave  (input stb_n, sclk_in, dio_in, output dio_out, dio_oe);
endinterface

// File: rtl/tm1638_responder_pin_sync.sv
// Multi-flop input synchronizer with rise/fall pulses on the synchronized copy.
module tm1638_pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {SYNC_STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign q    = chain[SYNC_STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/tm1638_responder.sv
// TM1638 device emulation: decodes master frames into display RAM/control and
// shifts key-scan bytes back on read commands.
module tm1638_responder
  import tm1638_responder_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  tm1638_responder_if.slave   pins,
  input  logic [31:0]         keys,
  input  logic [3:0]          ram_raddr,
  output logic [7:0]          ram_rdata,
  output logic                ram_we,
  output logic [3:0]          ram_waddr,
  output logic [7:0]          ram_wdata,
  output logic                display_on,
  output logic [2:0]          brightness
);

  logic stb_q, stb_rise, stb_fall;
  logic sclk_q, sclk_rise, sclk_fall;
  logic dio_s, dio_rise, dio_fall;

  // stb resets low so a strobe already held low through reset never looks like a new frame
  tm1638_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_stb (
    .clk(clk), .rst(rst), .d(pins.stb_n), .q(stb_q), .rise(stb_rise), .fall(stb_fall));
  tm1638_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(pins.sclk_in), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
  tm1638_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_dio (
    .clk(clk), .rst(rst), .d(pins.dio_in), .q(dio_s), .rise(dio_rise), .fall(dio_fall));

  logic unused_pins;
  assign unused_pins = &{1'b0, stb_q, sclk_q, dio_rise, dio_fall};

  state_t           state, state_d;
  logic [7:0]       sh;
  logic [2:0]       bit_cnt;
  logic             byte_done;
  logic             mode_read, mode_fixed;
  logic [3:0]       ptr;
  logic [3:0][7:0]  snap;
  logic [2:0]       rd_idx;
  logic [2:0]       rd_bit;
  logic [15:0][7:0] ram;
  logic             cmd_act, wr_act;

  assign ram_rdata = ram[ram_raddr];

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    cmd_act = 1'b0;
    wr_act  = 1'b0;
    unique case (state)
      S_IDLE: if (stb_fall) state_d = S_CMD;
      S_CMD: if (byte_done) begin
        cmd_act = 1'b1;
        if (cmd_field(sh) == CMD_DATA && sh[BIT_READ])     state_d = S_RDATA;
        else if (cmd_field(sh) == CMD_ADDR && !mode_read)  state_d = S_WDATA;
        else                                               state_d = S_IGNORE;
      end
      S_WDATA: wr_act = byte_done;
      default: ;
    endcase
    // strobe release wins over anything completing in the same cycle
    if (stb_rise) begin
      state_d = S_IDLE;
      cmd_act = 1'b0;
      wr_act  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh           <= '0;
      bit_cnt      <= '0;
      byte_done    <= 1'b0;
      mode_read    <= 1'b0;
      mode_fixed   <= 1'b0;
      ptr          <= '0;
      snap         <= '0;
      rd_idx       <= '0;
      rd_bit       <= '0;
      ram          <= '0;
      ram_we       <= 1'b0;
      ram_waddr    <= '0;
      ram_wdata    <= '0;
      display_on   <= 1'b0;
      brightness   <= '0;
      pins.dio_out <= 1'b0;
      pins.dio_oe  <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (state == S_IDLE || stb_rise) begin
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        sh        <= {dio_s, sh[7:1]};
        bit_cnt   <= bit_cnt + 3'd1;
        byte_done <= (bit_cnt == 3'd7);
      end

      if (cmd_act) begin
        unique case (cmd_field(sh))
          CMD_DATA: begin
            mode_read  <= sh[BIT_READ];
            mode_fixed <= sh[BIT_FIXED];
            if (sh[BIT_READ]) begin
              snap   <= keys;
              rd_idx <= '0;
              rd_bit <= '0;
            end
          end
          CMD_ADDR: ptr <= sh[3:0];
          CMD_DISP: begin
            display_on <= sh[BIT_DISP_ON];
            brightness <= sh[2:0];
          end
          default: ;
        endcase
      end

      ram_we <= wr_act;
      if (wr_act) begin
        ram_waddr <= ptr;
        ram_wdata <= sh;
        if (!mode_fixed) ptr <= ptr + 4'd1;
      end
      // storage lags the ram_we pulse by one cycle
      if (ram_we) ram[ram_waddr] <= ram_wdata;

      pins.dio_oe <= (state_d == S_RDATA);
      if (state_d != S_RDATA) begin
        pins.dio_out <= 1'b0;
      end else if (state == S_RDATA && sclk_fall) begin
        pins.dio_out <= (rd_idx < 3'd4) ? snap[rd_idx[1:0]][rd_bit] : 1'b0;
        rd_bit       <= rd_bit + 3'd1;
        if (rd_bit == 3'd7 && rd_idx < 3'd4) rd_idx <= rd_idx + 3'd1;
      end
    end
  end

endmodule
